// File: rtl/fir_input_buffer.sv
// FIR input buffer: a small first-word fall-through FIFO between an upstream
// sample source and the FIR controller. The head sample is presented
// combinationally and is consumed by a one-cycle get_input pulse.
module fir_input_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8      // power of two, at least 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       clear,
    output logic                       input_valid,
    output logic [DATA_W-1:0]          fir_data,
    input  logic                       get_input,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              underflow_q;
    logic              push;
    logic              pop;

    // Occupancy flags, handshake and fall-through head, all from registered state.
    always_comb begin
        empty         = (count_q == '0);
        full          = (count_q == FULL_CNT);
        in_ready      = !full;
        input_valid   = !empty;
        count         = count_q;
        underflow_err = underflow_q;
        fir_data      = mem[rd_ptr];
        // clear wins over both transfers; a full buffer never accepts, even
        // when a pop frees a slot in the same cycle.
        push          = in_valid && !full && !clear;
        pop           = get_input && !empty && !clear;
    end

    // Pointer, occupancy and sticky underflow control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (get_input && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Sample storage; deliberately not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_fir_input_buffer.sv
// Self-checking bench for fir_input_buffer: a directed vector table, hand
// sequences for the multi-cycle corner cases, and randomized traffic checked
// against a queue-based model of the buffer.
module tb_fir_input_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              clear = 1'b0;
    logic              input_valid;
    logic [DATA_W-1:0] fir_data;
    logic              get_input = 1'b0;
    logic [3:0]        count;
    logic              full;
    logic              empty;
    logic              underflow_err;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered samples plus sticky error flag.
    logic [DATA_W-1:0] mq[$];
    logic              m_uf = 1'b0;

    fir_input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .clear(clear), .input_valid(input_valid),
        .fir_data(fir_data), .get_input(get_input), .count(count),
        .full(full), .empty(empty), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        int n;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("in_ready", 32'(in_ready), 32'(n != DEPTH));
        chk("input_valid", 32'(input_valid), 32'(n != 0));
        chk("underflow_err", 32'(underflow_err), 32'(m_uf));
        if (n != 0) chk("fir_data", 32'(fir_data), 32'(mq[0]));
    endtask

    // Drive one cycle of inputs, advance the model by the buffer rules, then
    // clock the DUT and compare just after the edge.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                         input logic g, input logic c);
        bit was_full, was_empty;
        in_valid = v; in_data = d; get_input = g; clear = c;
        if (c) begin
            mq.delete();
            m_uf = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (g && was_empty) m_uf = 1'b1;
            if (g && !was_empty) void'(mq.pop_front());
            if (v && !was_full) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; get_input = 1'b0; clear = 1'b0;
        chk_model();
    endtask

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              g;
        logic              c;
        int                exp_count;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_data;
        logic              exp_uf;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [DATA_W-1:0] pops[$];

        // Reset asserted before any clock edge: outputs must follow at once.
        #2 rst_n = 1'b0;
        #1;
        chk("rst count", 32'(count), 0);
        chk("rst empty", 32'(empty), 1);
        chk("rst full", 32'(full), 0);
        chk("rst in_ready", 32'(in_ready), 1);
        chk("rst input_valid", 32'(input_valid), 0);
        chk("rst underflow", 32'(underflow_err), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Directed table: three pushes, drain, underflow, sticky hold, clear.
        tbl[0]  = '{1, 16'h0011, 0, 0, 1, 1, 16'h0011, 0};
        tbl[1]  = '{1, 16'h0022, 0, 0, 2, 1, 16'h0011, 0};
        tbl[2]  = '{1, 16'h0033, 0, 0, 3, 1, 16'h0011, 0};
        tbl[3]  = '{0, 16'h0000, 1, 0, 2, 1, 16'h0022, 0};
        tbl[4]  = '{0, 16'h0000, 1, 0, 1, 1, 16'h0033, 0};
        tbl[5]  = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0};
        tbl[6]  = '{0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1};
        tbl[7]  = '{0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1};
        tbl[8]  = '{1, 16'h0044, 0, 0, 1, 1, 16'h0044, 1};
        tbl[9]  = '{0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0};
        tbl[10] = '{1, 16'h0055, 0, 1, 0, 0, 16'h0000, 0};
        tbl[11] = '{1, 16'h0066, 0, 0, 1, 1, 16'h0066, 0};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].g, tbl[i].c);
            chk($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].exp_count));
            chk($sformatf("tbl%0d valid", i), 32'(input_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d uf", i), 32'(underflow_err), 32'(tbl[i].exp_uf));
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d data", i), 32'(fir_data), 32'(tbl[i].exp_data));
        end
        cycle(0, 0, 0, 1);

        // Fill to full, hold a 9th sample, pop once, then drain across the wrap.
        for (int i = 0; i < DEPTH; i++) cycle(1, 16'h0100 + 16'(i), 0, 0);
        chk("full after 8", 32'(full), 1);
        chk("in_ready after 8", 32'(in_ready), 0);
        cycle(1, 16'h0108, 0, 0);
        chk("9th held count", 32'(count), 8);
        cycle(1, 16'h0108, 1, 0);
        chk("pop while full count", 32'(count), 7);
        cycle(1, 16'h0108, 0, 0);
        chk("9th accepted count", 32'(count), 8);
        while (count != 0 && pops.size() < 16) begin
            pops.push_back(fir_data);
            cycle(0, 0, 1, 0);
        end
        chk("drain length", 32'(pops.size()), 8);
        for (int i = 0; i < 8 && i < pops.size(); i++)
            chk($sformatf("pop order %0d", i), 32'(pops[i]), 32'(16'h0101 + 16'(i)));

        // Simultaneous push and pop at count 4.
        for (int i = 0; i < 4; i++) cycle(1, 16'h0A00 + 16'(i), 0, 0);
        cycle(1, 16'h0AAA, 1, 0);
        chk("push+pop count", 32'(count), 4);
        chk("push+pop head", 32'(fir_data), 32'h0A01);

        // clear with push and pop at count 5.
        cycle(1, 16'h0BBB, 0, 0);
        cycle(1, 16'h0CCC, 1, 1);
        chk("clear count", 32'(count), 0);
        chk("clear empty", 32'(empty), 1);

        // Asynchronous reset between edges with three samples buffered.
        for (int i = 0; i < 3; i++) cycle(1, 16'h0D00 + 16'(i), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async count", 32'(count), 0);
        chk("async input_valid", 32'(input_valid), 0);
        chk("async in_ready", 32'(in_ready), 1);
        mq.delete();
        m_uf = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        cycle(1, 16'h0E0E, 0, 0);
        chk("first push after reset", 32'(fir_data), 32'h0E0E);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 55), 16'($urandom),
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_input_buffer.md
FIR_INPUT_BUFFER -- requirements
Module: fir_input_buffer

Interface
REQ-001 Parameter DATA_W, default 16, sample width in bits.
REQ-002 Parameter DEPTH, default 8, buffer entries; SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  DATA_W  sample from upstream source.
REQ-006 in_valid  input  1  upstream asserts when in_data is valid.
REQ-007 in_ready  output  1  buffer can accept a sample this cycle.
REQ-008 clear  input  1  synchronous discard of all buffered samples.
REQ-009 input_valid  output  1  a sample is available to the FIR controller.
REQ-010 fir_data  output  DATA_W  head-of-buffer sample presented to the FIR datapath.
REQ-011 get_input  input  1  one-cycle pulse from the FIR controller that consumes the head sample.
REQ-012 count  output  $clog2(DEPTH)+1  number of buffered samples.
REQ-013 full, empty  output  1 each  buffer occupancy flags.
REQ-014 underflow_err  output  1  sticky: get_input arrived while empty.

Function
REQ-015 Storage SHALL be DEPTH x DATA_W registers with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 Push occurs when in_valid && in_ready: mem[wr_ptr] <= in_data, wr_ptr increments.
REQ-017 in_ready SHALL equal !full; no push SHALL occur when full, even if a pop happens in the same cycle.
REQ-018 Pop occurs when get_input && !empty: rd_ptr increments.
REQ-019 get_input while empty SHALL leave pointers and count unchanged and set underflow_err on the next edge.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 count SHALL increment on push-only, decrement on pop-only, and hold otherwise; empty = (count==0), full = (count==DEPTH).
REQ-022 Read is first-word fall-through: fir_data SHALL equal mem[rd_ptr] combinationally whenever !empty and SHALL stay stable until the pop; its value when empty is don't-care.
REQ-023 input_valid SHALL equal !empty, so a sample pushed at edge N is visible at input_valid and fir_data after edge N (latency 1).
REQ-024 The head sample SHALL stay unchanged between input_valid assertion and the get_input pulse, which the FIR controller issues one cycle later from its GET_INPUT state.
REQ-025 clear SHALL take priority over push and pop in the same cycle: pointers and count go to 0, underflow_err goes to 0, and in_data is not written.
REQ-026 underflow_err SHALL remain set until clear or reset.
REQ-027 Storage contents SHALL NOT be reset; only pointers, count and flags are reset.

Reset
REQ-028 While rst_n==0, pointers SHALL be 0, count SHALL be 0, empty SHALL be 1, full SHALL be 0, input_valid SHALL be 0, in_ready SHALL be 1, and underflow_err SHALL be 0, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL discard all buffered samples immediately.
REQ-030 After rst_n deasserts, the first push SHALL be accepted on the first rising edge.

Verification
REQ-031 Reset, then push 0x0011, 0x0022, 0x0033 on consecutive cycles -> count=3; input_valid=1 one cycle after the first push; fir_data=0x0011.
REQ-032 Push 8 samples 0x0100..0x0107 with DEPTH=8 -> full=1 and in_ready=0; a 9th sample held on in_valid is not accepted; after one get_input pulse the 9th sample is accepted the following cycle; the pop order is 0x0101..0x0107 and then the 9th sample (pointer wrap checked).
REQ-033 With count=4, assert push (0x0AAA) and get_input in the same cycle -> count stays 4 and the head advances to the next sample.
REQ-034 Pulse get_input with the buffer empty -> count stays 0 and underflow_err=1; underflow_err holds until clear; then clear=1 -> underflow_err=0.
REQ-035 With count=5, assert clear together with in_valid and get_input -> count=0, empty=1, and no write occurs.
REQ-036 With count=3, drop rst_n between clock edges -> count=0, input_valid=0, and in_ready=1 immediately, without waiting for a clock edge.
